// File: rtl/sort_pkg.sv
// Shared constants for the sort_array_avalon peripheral: control-space
// word indices, CTRL bit positions and the sort engine state encoding.
package sort_pkg;

   localparam int CTRL_IDX = 0;
   localparam int LEN_IDX  = 1;

   localparam int START_BIT = 0;
   localparam int DESC_BIT  = 1;
   localparam int BUSY_BIT  = 1;
   localparam int DONE_BIT  = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SORT = 1'b1
   } sort_state_t;

endpackage

// File: rtl/sort_cmp_swap.sv
// Single compare-exchange cell of the odd-even transposition network.
// lo_out lands on the lower array index, hi_out on the higher one.
module sort_cmp_swap #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              desc,
   input  logic              enable,
   output logic [DATA_W-1:0] lo_out,
   output logic [DATA_W-1:0] hi_out
);

   logic swap;

   // Strict compare so equal words stay where they are.
   assign swap   = enable & (desc ? (a < b) : (a > b));
   assign lo_out = swap ? b : a;
   assign hi_out = swap ? a : b;

endmodule

// File: rtl/sort_array_avalon.sv
// Avalon-MM slave holding a DEPTH-word array that can be sorted in place
// by an odd-even transposition engine, one phase per clock.
module sort_array_avalon
   import sort_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic [DATA_W-1:0] Q,
   output logic              done
);

   localparam int IDX_W = ADDR_W - 1;
   localparam int LEN_W = IDX_W + 1;

   sort_state_t       state_q, state_d;
   logic              done_q, done_d;
   logic              desc_q, desc_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  phase_q, phase_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] arr_q [DEPTH];
   logic [DATA_W-1:0] arr_d [DEPTH];

   logic [DATA_W-1:0] arr_sorted [DEPTH];
   logic [DATA_W-1:0] lo_w [DEPTH-1];
   logic [DATA_W-1:0] hi_w [DEPTH-1];
   logic [DEPTH-2:0]  pair_en;

   logic              busy;
   logic              wr_acc;
   logic              rd_acc;
   logic              is_ctrl;
   logic [IDX_W-1:0]  idx;

   assign busy    = (state_q == ST_SORT);
   assign is_ctrl = address[ADDR_W-1];
   assign idx     = address[IDX_W-1:0];
   // Every write is dropped while the engine owns the array.
   assign wr_acc  = chipselect & write & ~busy;
   assign rd_acc  = chipselect & read & ~write;

   always_comb begin
      for (int j = 0; j < DEPTH - 1; j++) begin
         pair_en[j] = busy
                      && ((j % 2) == int'(phase_q[0]))
                      && ((j + 1) < int'(len_q));
      end
   end

   for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cmp
      sort_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
         .a      (arr_q[g]),
         .b      (arr_q[g+1]),
         .desc   (desc_q),
         .enable (pair_en[g]),
         .lo_out (lo_w[g]),
         .hi_out (hi_w[g])
      );
   end

   // Pairs active in one phase never overlap, so each word has one source.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         arr_sorted[k] = arr_q[k];
      end
      for (int j = 0; j < DEPTH - 1; j++) begin
         if (pair_en[j]) begin
            arr_sorted[j]   = lo_w[j];
            arr_sorted[j+1] = hi_w[j];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = done_q;
      desc_d  = desc_q;
      len_d   = len_q;
      phase_d = phase_q;
      rdata_d = rdata_q;
      for (int k = 0; k < DEPTH; k++) begin
         arr_d[k] = arr_q[k];
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_acc) begin
               if (!is_ctrl) begin
                  arr_d[idx] = writedata;
               end else if (idx == IDX_W'(CTRL_IDX)) begin
                  desc_d = writedata[DESC_BIT];
                  if (writedata[START_BIT]) begin
                     if (len_q >= LEN_W'(2)) begin
                        done_d  = 1'b0;
                        phase_d = '0;
                        state_d = ST_SORT;
                     end else begin
                        done_d  = 1'b1;
                     end
                  end
               end else if (idx == IDX_W'(LEN_IDX)) begin
                  if (writedata > DATA_W'(DEPTH)) begin
                     len_d = LEN_W'(DEPTH);
                  end else begin
                     len_d = writedata[LEN_W-1:0];
                  end
               end
            end
         end
         ST_SORT: begin
            for (int k = 0; k < DEPTH; k++) begin
               arr_d[k] = arr_sorted[k];
            end
            phase_d = phase_q + LEN_W'(1);
            if (phase_q == len_q - LEN_W'(1)) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rd_acc) begin
         if (!is_ctrl) begin
            rdata_d = arr_q[idx];
         end else if (idx == IDX_W'(CTRL_IDX)) begin
            rdata_d           = '0;
            rdata_d[DONE_BIT] = done_q;
            rdata_d[BUSY_BIT] = busy;
            rdata_d[0]        = desc_q;
         end else if (idx == IDX_W'(LEN_IDX)) begin
            rdata_d = DATA_W'(len_q);
         end else begin
            rdata_d = '0;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         desc_q  <= 1'b0;
         len_q   <= LEN_W'(DEPTH);
         phase_q <= '0;
         rdata_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            arr_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         desc_q  <= desc_d;
         len_q   <= len_d;
         phase_q <= phase_d;
         rdata_q <= rdata_d;
         for (int k = 0; k < DEPTH; k++) begin
            arr_q[k] <= arr_d[k];
         end
      end
   end

   assign readdata = rdata_q;
   assign Q        = arr_q[0];
   assign done     = done_q;

endmodule

// File: tb/tb_sort_array_avalon.sv
// Directed bench for sort_array_avalon (DATA_W=32, DEPTH=8): host accesses
// through Avalon tasks, immediate-assertion checks, one summary line.
module tb_sort_array_avalon;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 4;

   localparam logic [ADDR_W-1:0] A_CTRL = 4'h8;
   localparam logic [ADDR_W-1:0] A_LEN  = 4'h9;

   logic              clock;
   logic              resetn;
   logic              chipselect;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic [DATA_W-1:0] Q;
   logic              done;

   int checks = 0;
   int errors = 0;

   sort_array_avalon #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .chipselect (chipselect),
      .read       (read),
      .write      (write),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .Q          (Q),
      .done       (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // All bus tasks start and end at a falling edge and span one clock.
   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clock);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(negedge clock);
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 50) begin
         @(negedge clock);
         cycles++;
      end
   endtask

   task automatic check_array(input string tag, input logic [DATA_W-1:0] exp [DEPTH]);
      logic [DATA_W-1:0] rd;
      for (int i = 0; i < DEPTH; i++) begin
         bus_read(ADDR_W'(i), rd);
         check($sformatf("%s[%0d]", tag, i), rd, exp[i]);
      end
   endtask

   task automatic load_array(input logic [DATA_W-1:0] v [DEPTH]);
      for (int i = 0; i < DEPTH; i++) begin
         bus_write(ADDR_W'(i), v[i]);
      end
   endtask

   logic [DATA_W-1:0] rd;
   int                cyc;
   logic [DATA_W-1:0] asc_in   [DEPTH] = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd4};
   logic [DATA_W-1:0] asc_exp  [DEPTH] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd8, 32'd9};
   logic [DATA_W-1:0] dsc_in   [DEPTH] = '{32'h10, 32'hFFFF_FFFF, 32'h3, 32'h3, 32'hAA, 32'h0, 32'h0, 32'h0};
   logic [DATA_W-1:0] dsc_exp  [DEPTH] = '{32'hFFFF_FFFF, 32'hAA, 32'h10, 32'h3, 32'h3, 32'h0, 32'h0, 32'h0};
   logic [DATA_W-1:0] zero_arr [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] deg_exp  [DEPTH] = '{32'd7, 32'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
   logic [DATA_W-1:0] rw_exp   [DEPTH] = '{32'd1, 32'd2, 32'd3, 32'h55, 32'd5, 32'd7, 32'd8, 32'd9};

   initial begin
      resetn = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
      address = '0; writedata = '0;
      repeat (2) @(negedge clock);
      check("rst_readdata", readdata, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_q", Q, 32'h0);
      resetn = 1'b1;
      @(negedge clock);
      bus_read(A_LEN, rd);
      check("rst_len", rd, 32'd8);
      bus_read(A_CTRL, rd);
      check("rst_ctrl", rd, 32'h0);

      // Ascending full-length sort
      load_array(asc_in);
      bus_write(A_LEN, 32'd8);
      bus_write(A_CTRL, 32'h1);
      check("asc_done_low_after_start", {31'h0, done}, 32'h0);
      bus_read(A_CTRL, rd);
      check("asc_busy_seen", rd, 32'h2);
      wait_done(cyc);
      check("asc_busy_cycles", 32'(cyc + 1), 32'd8);
      check("asc_q", Q, 32'd1);
      check_array("asc", asc_exp);
      bus_read(A_CTRL, rd);
      check("asc_ctrl", rd, 32'h4);

      // Descending partial-length sort, unsigned with duplicates
      load_array(dsc_in);
      bus_write(A_LEN, 32'd5);
      bus_write(A_CTRL, 32'h3);
      wait_done(cyc);
      check("dsc_busy_cycles", 32'(cyc), 32'd5);
      check("dsc_q", Q, 32'hFFFF_FFFF);
      check_array("dsc", dsc_exp);
      bus_read(A_CTRL, rd);
      check("dsc_ctrl", rd, 32'h5);

      // Writes during a sort must all be dropped
      load_array(asc_in);
      bus_write(A_LEN, 32'd8);
      bus_write(A_CTRL, 32'h1);
      bus_write(4'h0, 32'hDEAD);
      bus_write(A_LEN, 32'd2);
      bus_write(A_CTRL, 32'h3);
      wait_done(cyc);
      check("busy_wr_cycles", 32'(cyc + 3), 32'd8);
      check_array("busy_wr", asc_exp);
      bus_read(A_LEN, rd);
      check("busy_wr_len", rd, 32'd8);
      bus_read(A_CTRL, rd);
      check("busy_wr_ctrl", rd, 32'h4);

      // Back-to-back start on an already sorted array
      bus_write(A_CTRL, 32'h1);
      check("b2b_done_drop", {31'h0, done}, 32'h0);
      wait_done(cyc);
      check("b2b_busy_cycles", 32'(cyc), 32'd8);
      check_array("b2b", asc_exp);

      // Read and write in the same cycle: write lands, readdata holds
      bus_read(4'h2, rd);
      check("rw_pre_read", rd, 32'd3);
      chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 4'h3; writedata = 32'h55;
      @(negedge clock);
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      check("rw_readdata_held", readdata, 32'd3);
      check_array("rw", rw_exp);

      // Reset in the middle of a sort
      load_array(asc_in);
      bus_write(A_CTRL, 32'h1);
      repeat (3) @(negedge clock);
      resetn = 1'b0;
      #1;
      check("midrst_readdata", readdata, 32'h0);
      check("midrst_done", {31'h0, done}, 32'h0);
      check("midrst_q", Q, 32'h0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      bus_read(A_LEN, rd);
      check("midrst_len", rd, 32'd8);
      bus_read(A_CTRL, rd);
      check("midrst_ctrl", rd, 32'h0);
      check_array("midrst", zero_arr);

      // Degenerate lengths complete at once without touching the array
      bus_write(4'h0, 32'd7);
      bus_write(4'h1, 32'd3);
      bus_write(A_LEN, 32'd1);
      check("len1_done_pre", {31'h0, done}, 32'h0);
      bus_write(A_CTRL, 32'h1);
      check("len1_done", {31'h1 & 31'h0, done}, 32'h1);
      bus_read(A_CTRL, rd);
      check("len1_ctrl", rd, 32'h4);
      check_array("len1", deg_exp);
      bus_write(A_LEN, 32'd0);
      bus_write(A_CTRL, 32'h1);
      check("len0_done", {31'h0, done}, 32'h1);
      bus_read(A_CTRL, rd);
      check("len0_ctrl", rd, 32'h4);
      check_array("len0", deg_exp);
      bus_write(A_LEN, 32'd12);
      bus_read(A_LEN, rd);
      check("len_sat", rd, 32'd8);
      bus_read(4'hA, rd);
      check("unmapped_read", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sort_array_avalon.md
Name: sort_array_avalon

Overview:
- Parametrised Avalon-MM slave: host-loadable array of DEPTH words, DATA_W bits each, plus an in-place hardware sort engine.
- Host writes the words, sets length and direction, then writes START.
- Engine runs odd-even transposition sort, one phase per clock. Host polls DONE and reads the sorted words back.
- Sits in the Qsys system as a peripheral. Exports word 0 (min/max) and DONE to the outside.

Parameters:
- DATA_W, 32, word width in bits; must be >= clog2(DEPTH)+2.
- DEPTH, 8, number of array words; power of 2, >= 2.
- ADDR_W, clog2(DEPTH)+1, derived localparam (not overridable); Avalon word-address width.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- chipselect  in  1  Avalon slave select; read/write ignored when low.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  ADDR_W  word address; MSB=0 selects array, MSB=1 selects control space.
- writedata  in  DATA_W  Avalon write data.
- readdata  out  DATA_W  Avalon read data, registered, readLatency=1.
- Q  out  DATA_W  current contents of array word 0.
- done  out  1  sticky sort-complete flag.

Behaviour:
- Reset (async, resetn=0):
  - array words = 0; LEN = DEPTH; DESC = 0.
  - state = IDLE; busy = 0; done = 0; readdata = 0; phase counter = 0.
- Address map:
  - MSB=0: array[idx].
  - MSB=1, idx=0: CTRL. Write: bit0 START (write-1 pulse, not stored), bit1 DESC. Read: {0.., done(bit2), busy(bit1), DESC(bit0)}.
  - MSB=1, idx=1: LEN, range 0..DEPTH. Writes > DEPTH saturate to DEPTH.
  - MSB=1, other idx: reads 0, writes ignored.
- Reads: readdata updated on the clock edge after chipselect&read; holds its value otherwise. Reading the array while busy returns the current partially sorted contents.
- Writes: take effect at the clock edge with chipselect&write. If read and write are both high, the write is performed and readdata is not updated.
- While busy, all writes are ignored, including a second START, array, LEN and DESC writes.
- FSM IDLE:
  - START with LEN>=2: DESC latched from the same write; done<=0; phase<=0; go to SORT.
  - START with LEN<2: done<=1 on the next edge; array unchanged; stays IDLE.
- FSM SORT:
  - busy=1. Each cycle performs one phase p.
  - p even: compare-exchange pairs (0,1),(2,3),...
  - p odd: compare-exchange pairs (1,2),(3,4),...
  - Only pairs with j+1 < LEN take part; words >= LEN are never modified.
  - Exchange if (!DESC && a>b) or (DESC && a<b). Compare is unsigned; equal values are not swapped.
  - After phase LEN-1: done<=1, go to IDLE.
  - Busy lasts exactly LEN cycles; START-to-done latency is LEN+1 edges.
- done stays 1 until the next accepted START or reset.
- Q is combinational from array[0] and follows it during the sort.
- Reset mid-sort aborts immediately. The array is zeroed; no partial result is retained.

Decomposition:
- Shared package sort_pkg holds:
  - CTRL_IDX=0, LEN_IDX=1;
  - bit positions START=0, DESC=1, BUSY=1 (read), DONE=2 (read);
  - FSM state encoding IDLE/SORT.
- One sub-module, sort_cmp_swap: combinational compare-exchange parameterised on DATA_W, with inputs a, b, desc, enable and outputs lo_out, hi_out.
- The top instantiates DEPTH-1 copies, with even/odd enables set by phase parity and LEN.

Test Plan:
- Reset:
  - Stimulus: assert resetn=0 mid-operation.
  - Response: readdata=0, done=0, Q=0. Reading LEN gives 8; reading CTRL gives 0.
- Ascending sort, DEPTH=8:
  - Stimulus: write array {5,3,8,1,9,2,7,4}, LEN=8, then CTRL=0x1.
  - Response: busy for exactly 8 cycles, then done=1. Array reads {1,2,3,4,5,7,8,9}; Q=1.
- Descending sort with partial length:
  - Stimulus: array {0x10,0xFFFFFFFF,0x3,0x3,0xAA,0,0,0}, LEN=5, CTRL=0x3.
  - Response: words 0..4 = {0xFFFFFFFF,0xAA,0x10,0x3,0x3}; words 5..7 remain 0. Checks unsigned compare and equal values.
- Degenerate lengths:
  - Stimulus: LEN=1, START; then LEN=0, START.
  - Response: done=1 one edge later, busy never seen high, array unchanged. Writing LEN=12 reads back 8.
- Writes while busy:
  - Stimulus: during a sort, write array[0]=0xDEAD, LEN=2, and START.
  - Response: all ignored; the sort completes with the original result and the original 8-cycle busy window.
- Back-to-back:
  - Stimulus: START again right after done.
  - Response: done drops to 0 on the accepting edge; an already-sorted array is unchanged after 8 cycles; read/write on the same cycle performs the write only.
